// File: rtl/ctrl_mc_if.sv
// Instruction/handshake bundle between the program sequencer and the ctrl_mc controller.
// The sequencer side uses the master modport; the controller uses the slave modport.
interface ctrl_mc_if;
  logic [7:0] opcode;
  logic       fproc_ready;
  logic       sync_enable;
  logic       cstrobe_in;
  logic       err_clr;

  logic [2:0] alu_opcode;
  logic       alu_in0_sel;
  logic [1:0] alu_in1_sel;
  logic       c_strobe_enable;
  logic       reg_write_en;
  logic       instr_ptr_en;
  logic [1:0] instr_ptr_load_en;
  logic       qclk_load_en;
  logic       sync_out_ready;
  logic       fproc_out_ready;
  logic       write_pulse_en;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output opcode, fproc_ready, sync_enable, cstrobe_in, err_clr,
    input  alu_opcode, alu_in0_sel, alu_in1_sel, c_strobe_enable, reg_write_en,
           instr_ptr_en, instr_ptr_load_en, qclk_load_en, sync_out_ready,
           fproc_out_ready, write_pulse_en, done, err, err_code
  );

  modport slave (
    input  opcode, fproc_ready, sync_enable, cstrobe_in, err_clr,
    output alu_opcode, alu_in0_sel, alu_in1_sel, c_strobe_enable, reg_write_en,
           instr_ptr_en, instr_ptr_load_en, qclk_load_en, sync_out_ready,
           fproc_out_ready, write_pulse_en, done, err, err_code
  );
endinterface

// File: rtl/ctrl_mc.sv
// Instruction-sequencing control FSM: decodes the opcode class in INIT and walks the
// ALU / jump / qclk / fproc / sync handshakes, with bounded waits that trap into ERROR.
module ctrl_mc #(
  parameter int FPROC_TIMEOUT = 1024,
  parameter int SYNC_TIMEOUT  = 1024,
  parameter int CNT_W         = 16
) (
  input logic       clk,
  input logic       reset_n,
  ctrl_mc_if.slave  bus
);

  typedef enum logic [3:0] {
    S_INIT, S_ALU_PROC, S_JUMP_COND, S_INC_QCLK, S_ALU_FPROC_WAIT,
    S_JUMP_FPROC_WAIT, S_SYNC_WAIT, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] SEL_REG   = 2'd0;
  localparam logic [1:0] SEL_QCLK  = 2'd1;
  localparam logic [1:0] SEL_FPROC = 2'd2;
  localparam logic [1:0] LD_TRUE   = 2'd1;
  localparam logic [1:0] LD_ALU    = 2'd2;

  localparam bit              FPROC_TO_EN = (FPROC_TIMEOUT != 0);
  localparam bit              SYNC_TO_EN  = (SYNC_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] FPROC_LIMIT = CNT_W'(FPROC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SYNC_LIMIT  = CNT_W'(SYNC_TIMEOUT - 1);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [1:0]       r_err_code, w_err_code_next;
  logic [7:0]       r_opcode;
  logic             r_from_fproc;
  logic [3:0]       w_cls;

  logic [2:0] w_alu_opcode;
  logic       w_alu_in0_sel;
  logic [1:0] w_alu_in1_sel;
  logic       w_c_strobe_enable, w_reg_write_en, w_instr_ptr_en;
  logic [1:0] w_instr_ptr_load_en;
  logic       w_qclk_load_en, w_sync_out_ready, w_fproc_out_ready;
  logic       w_write_pulse_en, w_done, w_err;

  assign w_cls     = bus.opcode[7:4];
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_next              = r_state;
    w_cnt_next          = r_cnt;
    w_err_code_next     = r_err_code;
    w_alu_opcode        = r_opcode[2:0];
    w_alu_in0_sel       = r_opcode[3];
    w_alu_in1_sel       = SEL_REG;
    w_c_strobe_enable   = 1'b0;
    w_reg_write_en      = 1'b0;
    w_instr_ptr_en      = 1'b0;
    w_instr_ptr_load_en = 2'd0;
    w_qclk_load_en      = 1'b0;
    w_sync_out_ready    = 1'b0;
    w_fproc_out_ready   = 1'b0;
    w_write_pulse_en    = 1'b0;
    w_done              = 1'b0;
    w_err               = 1'b0;

    unique case (r_state)
      S_INIT: begin
        w_cnt_next    = '0;
        w_alu_opcode  = bus.opcode[2:0];
        w_alu_in0_sel = bus.opcode[3];
        case (w_cls)
          4'h1: begin w_write_pulse_en = 1'b1; w_instr_ptr_en = 1'b1; end
          4'h2: begin
            w_write_pulse_en  = 1'b1;
            w_c_strobe_enable = 1'b1;
            w_instr_ptr_en    = bus.cstrobe_in;
          end
          4'h3: w_next = S_ALU_PROC;
          4'h4: begin w_instr_ptr_load_en = LD_TRUE; w_instr_ptr_en = 1'b1; end
          4'h5: w_next = S_JUMP_COND;
          4'h6: begin w_alu_in1_sel = SEL_QCLK; w_next = S_INC_QCLK; end
          4'h7: begin w_fproc_out_ready = 1'b1; w_next = S_ALU_FPROC_WAIT; end
          4'h8: begin w_fproc_out_ready = 1'b1; w_next = S_JUMP_FPROC_WAIT; end
          4'h9: begin w_sync_out_ready = 1'b1; w_next = S_SYNC_WAIT; end
          4'hA: w_next = S_DONE;
          default: begin
            // Illegal class: fully idle and the PC stalls on this instruction.
            w_alu_opcode  = 3'd0;
            w_alu_in0_sel = 1'b0;
          end
        endcase
      end
      S_ALU_PROC: begin
        w_reg_write_en = 1'b1;
        w_instr_ptr_en = 1'b1;
        w_alu_in1_sel  = r_from_fproc ? SEL_FPROC : SEL_REG;
        w_next         = S_INIT;
      end
      S_JUMP_COND: begin
        w_instr_ptr_load_en = LD_ALU;
        w_instr_ptr_en      = 1'b1;
        w_alu_in1_sel       = r_from_fproc ? SEL_FPROC : SEL_REG;
        w_next              = S_INIT;
      end
      S_INC_QCLK: begin
        w_alu_in1_sel  = SEL_QCLK;
        w_qclk_load_en = 1'b1;
        w_instr_ptr_en = 1'b1;
        w_next         = S_INIT;
      end
      S_ALU_FPROC_WAIT, S_JUMP_FPROC_WAIT: begin
        w_alu_in1_sel = SEL_FPROC;
        if (bus.fproc_ready) begin
          w_next = (r_state == S_ALU_FPROC_WAIT) ? S_ALU_PROC : S_JUMP_COND;
        end else if (FPROC_TO_EN && r_cnt == FPROC_LIMIT) begin
          w_next          = S_ERROR;
          w_err_code_next = 2'd1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_SYNC_WAIT: begin
        w_alu_opcode  = 3'd0;
        w_alu_in0_sel = 1'b0;
        if (bus.sync_enable) begin
          w_instr_ptr_en = 1'b1;
          w_next         = S_INIT;
        end else if (SYNC_TO_EN && r_cnt == SYNC_LIMIT) begin
          w_next          = S_ERROR;
          w_err_code_next = 2'd2;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_DONE: begin
        w_alu_opcode  = 3'd0;
        w_alu_in0_sel = 1'b0;
        w_done        = 1'b1;
      end
      S_ERROR: begin
        w_alu_opcode  = 3'd0;
        w_alu_in0_sel = 1'b0;
        w_err         = 1'b1;
        if (bus.err_clr) begin
          w_next          = S_INIT;
          w_err_code_next = 2'd0;
        end
      end
      default: w_next = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_INIT;
      r_cnt        <= '0;
      r_err_code   <= 2'd0;
      r_opcode     <= 8'd0;
      r_from_fproc <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_err_code   <= w_err_code_next;
      r_opcode     <= (r_state == S_INIT) ? bus.opcode : r_opcode;
      r_from_fproc <= (r_state == S_ALU_FPROC_WAIT) || (r_state == S_JUMP_FPROC_WAIT);
    end
  end

  // INIT decodes the live opcode, so outputs are gated by reset_n directly, not just by state.
  always_comb begin
    bus.alu_opcode        = reset_n ? w_alu_opcode        : 3'd0;
    bus.alu_in0_sel       = reset_n ? w_alu_in0_sel       : 1'b0;
    bus.alu_in1_sel       = reset_n ? w_alu_in1_sel       : SEL_REG;
    bus.c_strobe_enable   = reset_n ? w_c_strobe_enable   : 1'b0;
    bus.reg_write_en      = reset_n ? w_reg_write_en      : 1'b0;
    bus.instr_ptr_en      = reset_n ? w_instr_ptr_en      : 1'b0;
    bus.instr_ptr_load_en = reset_n ? w_instr_ptr_load_en : 2'd0;
    bus.qclk_load_en      = reset_n ? w_qclk_load_en      : 1'b0;
    bus.sync_out_ready    = reset_n ? w_sync_out_ready    : 1'b0;
    bus.fproc_out_ready   = reset_n ? w_fproc_out_ready   : 1'b0;
    bus.write_pulse_en    = reset_n ? w_write_pulse_en    : 1'b0;
    bus.done              = reset_n ? w_done              : 1'b0;
    bus.err               = reset_n ? w_err               : 1'b0;
    bus.err_code          = reset_n ? r_err_code          : 2'd0;
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc: instance A covers decode, fproc/sync handshakes, sync timeout,
// reset and DONE; instance B (FPROC_TIMEOUT=4, unbounded sync, 3-bit counter) covers fproc timeout.
module tb_ctrl_mc;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  ctrl_mc_if ifa();
  ctrl_mc_if ifb();

  ctrl_mc #(.FPROC_TIMEOUT(16), .SYNC_TIMEOUT(6), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
  ctrl_mc #(.FPROC_TIMEOUT(4), .SYNC_TIMEOUT(0), .CNT_W(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

  always #5 clk = ~clk;

  logic [15:0] ctrl_a, ctrl_b;
  assign ctrl_a = {ifa.alu_opcode, ifa.alu_in0_sel, ifa.alu_in1_sel, ifa.c_strobe_enable,
                   ifa.reg_write_en, ifa.instr_ptr_en, ifa.instr_ptr_load_en, ifa.qclk_load_en,
                   ifa.sync_out_ready, ifa.fproc_out_ready, ifa.write_pulse_en};
  assign ctrl_b = {ifb.alu_opcode, ifb.alu_in0_sel, ifb.alu_in1_sel, ifb.c_strobe_enable,
                   ifb.reg_write_en, ifb.instr_ptr_en, ifb.instr_ptr_load_en, ifb.qclk_load_en,
                   ifb.sync_out_ready, ifb.fproc_out_ready, ifb.write_pulse_en};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.opcode = 8'h10; ifa.fproc_ready = 0; ifa.sync_enable = 0; ifa.cstrobe_in = 0; ifa.err_clr = 0;
    ifb.opcode = 8'h00; ifb.fproc_ready = 0; ifb.sync_enable = 0; ifb.cstrobe_in = 0; ifb.err_clr = 0;

    // Reset: outputs gated even though INIT would decode PULSE_WRITE
    #3;
    check("rst_ctrl", ctrl_a, 0);
    check("rst_done_err", {ifa.done, ifa.err, ifa.err_code}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("pw_wpe", ifa.write_pulse_en, 1);
    check("pw_ipen", ifa.instr_ptr_en, 1);
    tick();

    // REG_ALU 0x31; opcode changed after decode must not affect ALU_PROC
    ifa.opcode = 8'h31; #1;
    check("alu_c0_ipen", ifa.instr_ptr_en, 0);
    check("alu_c0_rwe", ifa.reg_write_en, 0);
    tick();
    ifa.opcode = 8'h17; #1;
    check("alu_c1_rwe", ifa.reg_write_en, 1);
    check("alu_c1_ipen", ifa.instr_ptr_en, 1);
    check("alu_c1_aluop", ifa.alu_opcode, 3'd1);
    check("alu_c1_in1", ifa.alu_in1_sel, 0);
    tick();
    check("alu_c2_init", ifa.write_pulse_en, 1);

    // PULSE_WRITE_TRIG 0x20, strobe low 5 cycles then high
    ifa.opcode = 8'h20; #1;
    for (int i = 0; i < 5; i++) begin
      check("pwt_wpe", ifa.write_pulse_en, 1);
      check("pwt_cse", ifa.c_strobe_enable, 1);
      check("pwt_ipen_lo", ifa.instr_ptr_en, 0);
      tick();
    end
    ifa.cstrobe_in = 1; #1;
    check("pwt_wpe_strobe", ifa.write_pulse_en, 1);
    check("pwt_ipen_hi", ifa.instr_ptr_en, 1);
    tick();
    ifa.cstrobe_in = 0;

    // JUMP_I
    ifa.opcode = 8'h40; #1;
    check("jmpi_ld", ifa.instr_ptr_load_en, 1);
    check("jmpi_ipen", ifa.instr_ptr_en, 1);
    tick();

    // INC_QCLK
    ifa.opcode = 8'h60; #1;
    check("iq_c0", {ifa.alu_in1_sel, ifa.instr_ptr_en, ifa.qclk_load_en}, {2'd1, 1'b0, 1'b0});
    tick();
    check("iq_c1", {ifa.alu_in1_sel, ifa.instr_ptr_en, ifa.qclk_load_en}, {2'd1, 1'b1, 1'b1});
    tick();

    // JUMP_FPROC 0x80, ready after 7 wait cycles
    ifa.opcode = 8'h80; #1;
    check("jf_for", ifa.fproc_out_ready, 1);
    tick();
    for (int i = 0; i < 7; i++) begin
      check("jf_wait", {ifa.alu_in1_sel, ifa.fproc_out_ready, ifa.err}, {2'd2, 1'b0, 1'b0});
      tick();
    end
    ifa.fproc_ready = 1; #1;
    check("jf_rel_in1", ifa.alu_in1_sel, 2);
    tick();
    ifa.fproc_ready = 0; #1;
    check("jf_jc", {ifa.instr_ptr_load_en, ifa.instr_ptr_en, ifa.alu_in1_sel}, {2'd2, 1'b1, 2'd2});
    check("jf_err", ifa.err, 0);
    tick();

    // SYNC 0x90, enable on 3rd wait cycle, then an illegal opcode stalls in INIT
    ifa.opcode = 8'h90; #1;
    check("sy_sor", ifa.sync_out_ready, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      check("sy_wait", {ifa.sync_out_ready, ifa.instr_ptr_en}, 0);
      tick();
    end
    ifa.sync_enable = 1; #1;
    check("sy_ipen", ifa.instr_ptr_en, 1);
    tick();
    ifa.sync_enable = 0; ifa.opcode = 8'hF0; #1;
    check("ill_c0", ctrl_a, 0);
    tick();
    check("ill_c1", ctrl_a, 0);

    // Sync timeout (6 cycles) -> ERROR code 2, err_clr retries the SYNC
    ifa.opcode = 8'h90; tick();
    for (int i = 0; i < 6; i++) begin
      check("sto_wait_err", ifa.err, 0);
      tick();
    end
    check("sto_err", {ifa.err, ifa.err_code}, {1'b1, 2'd2});
    check("sto_ctrl", ctrl_a, 0);
    tick();
    check("sto_hold", ifa.err, 1);
    ifa.err_clr = 1; #1;
    check("sto_clr_same", ifa.err, 1);
    tick();
    ifa.err_clr = 0; #1;
    check("sto_retry", {ifa.err, ifa.err_code, ifa.sync_out_ready}, {1'b0, 2'd0, 1'b1});
    tick();

    // Reset mid SYNC_WAIT between edges
    ifa.sync_enable = 1; #1;
    check("mrst_pre", ifa.instr_ptr_en, 1);
    reset_n = 1'b0; #1;
    check("mrst_ctrl", ctrl_a, 0);
    ifa.sync_enable = 0;
    @(posedge clk); #2;
    reset_n = 1'b1; #1;
    check("mrst_init", ifa.sync_out_ready, 1);
    tick();
    ifa.sync_enable = 1; #1;
    check("mrst_rel", ifa.instr_ptr_en, 1);
    tick();
    ifa.sync_enable = 0;

    // DONE 0xA0 holds regardless of opcode
    ifa.opcode = 8'hA0; #1;
    check("dn_c0", {ctrl_a, ifa.done}, 0);
    tick();
    ifa.opcode = 8'h10;
    for (int i = 0; i < 3; i++) begin
      check("dn_done", ifa.done, 1);
      check("dn_ctrl", {ctrl_a, ifa.err}, 0);
      tick();
    end

    // Instance B: ALU_FPROC timeout after 4 wait cycles, code 1
    ifb.opcode = 8'h70; #1;
    check("bto_for", ifb.fproc_out_ready, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("bto_wait", {ifb.err, ifb.alu_in1_sel}, {1'b0, 2'd2});
      tick();
    end
    check("bto_err", {ifb.err, ifb.err_code, ifb.fproc_out_ready}, {1'b1, 2'd1, 1'b0});
    ifb.err_clr = 1; tick();
    ifb.err_clr = 0; #1;
    check("bto_clr", {ifb.err, ifb.err_code, ifb.fproc_out_ready}, {1'b0, 2'd0, 1'b1});
    tick();

    // Ready on the 4th wait cycle wins over the timeout
    for (int i = 0; i < 3; i++) tick();
    ifb.fproc_ready = 1; #1;
    check("bok_last_err", ifb.err, 0);
    tick();
    ifb.fproc_ready = 0; ifb.opcode = 8'h00; #1;
    check("bok_alu", {ifb.reg_write_en, ifb.instr_ptr_en, ifb.alu_in1_sel, ifb.err},
          {1'b1, 1'b1, 2'd2, 1'b0});
    tick();
    check("bok_idle", ctrl_b, 0);

    // Unbounded sync wait (SYNC_TIMEOUT=0) well past counter saturation
    ifb.opcode = 8'h90; tick();
    ifb.opcode = 8'h00;
    repeat (20) tick();
    check("bun_err", {ifb.err, ifb.err_code, ifb.sync_out_ready}, 0);
    ifb.sync_enable = 1; #1;
    check("bun_rel", ifb.instr_ptr_en, 1);
    tick();
    ifb.sync_enable = 0; #1;
    check("bun_init", ctrl_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
